// File: rtl/load_store_unit_if.sv
// load_store_unit_if: CPU request/response handshake plus data RAM port
interface load_store_unit_if #(parameter int ADDR_WIDTH = 15);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic                  d_we;
    logic [3:0]            d_be;
    logic [31:0]           d_wdata;
    logic [31:0]           d_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, d_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, d_addr, d_we, d_be, d_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, d_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, d_addr, d_we, d_be, d_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word load-store sequencer onto a one-cycle-latency word RAM
module load_store_unit #(parameter int ADDR_WIDTH = 15) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MEM, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic        accept, err;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_data;

    assign bus.req_ready = state == IDLE;
    assign accept = bus.req_valid && state == IDLE;
    // misalignment is judged on the low address bits; illegal encodings differ for loads and stores
    assign err = (bus.req_we ? bus.req_funct3 > 3'd2
                             : bus.req_funct3 == 3'd3 || bus.req_funct3 == 3'd6 || bus.req_funct3 == 3'd7)
              || (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0])
              || (bus.req_funct3 == 3'd2 && bus.req_addr[1:0] != 2'd0);

    assign be_calc = bus.req_funct3[1:0] == 2'd0 ? 4'b0001 << bus.req_addr[1:0]
                   : bus.req_funct3[1:0] == 2'd1 ? (bus.req_addr[1] ? 4'b1100 : 4'b0011)
                   : 4'b1111;
    assign wdata_calc = bus.req_funct3[1:0] == 2'd0 ? {4{bus.req_wdata[7:0]}}
                      : bus.req_funct3[1:0] == 2'd1 ? {2{bus.req_wdata[15:0]}}
                      : bus.req_wdata;

    assign byte_val  = bus.d_rdata[{off, 3'b000} +: 8];
    assign half_val  = off[1] ? bus.d_rdata[31:16] : bus.d_rdata[15:0];
    assign load_data = funct3[1:0] == 2'd0 ? {{24{~funct3[2] & byte_val[7]}}, byte_val}
                     : funct3[1:0] == 2'd1 ? {{16{~funct3[2] & half_val[15]}}, half_val}
                     : bus.d_rdata;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // errors skip the RAM entirely; loads need an extra cycle for read data to return
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? (err ? RESP : MEM) : IDLE;
            MEM:     state_next = we ? RESP : WAIT;
            WAIT:    state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    // registered RAM and response outputs plus the request fields needed after accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we              <= 1'b0;
            funct3          <= 3'd0;
            off             <= 2'd0;
            bus.d_addr      <= '0;
            bus.d_we        <= 1'b0;
            bus.d_be        <= 4'd0;
            bus.d_wdata     <= 32'd0;
            bus.resp_valid  <= 1'b0;
            bus.resp_err    <= 1'b0;
            bus.resp_rdata  <= 32'd0;
        end else begin
            if (accept) begin
                we     <= bus.req_we;
                funct3 <= bus.req_funct3;
                off    <= bus.req_addr[1:0];
            end
            if (accept && !err) bus.d_addr <= bus.req_addr[ADDR_WIDTH+1:2];
            if (accept && !err && bus.req_we) bus.d_wdata <= wdata_calc;
            bus.d_we       <= accept && !err && bus.req_we;
            bus.d_be       <= accept && !err && bus.req_we ? be_calc : 4'd0;
            bus.resp_valid <= state_next == RESP;
            bus.resp_err   <= accept && err;
            bus.resp_rdata <= state == WAIT ? load_data : 32'd0;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit against a behavioural word RAM
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   fails = 0;
    int   total = 0;

    load_store_unit_if #(.ADDR_WIDTH(15)) bus ();

    load_store_unit #(.ADDR_WIDTH(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // byte-enabled word RAM, read data one cycle after address is sampled
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.d_we)
            for (int i = 0; i < 4; i++)
                if (bus.d_be[i]) mem[bus.d_addr[7:0]][8*i +: 8] <= bus.d_wdata[8*i +: 8];
        bus.d_rdata <= mem[bus.d_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // issue one request at a falling edge; check MEM-cycle outputs, latency and response
    task automatic req(input string tag, input logic we, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, input int exp_lat, input logic exp_err,
                       input logic [31:0] exp_rd, input logic [31:0] exp_daddr,
                       input logic [3:0] exp_be, input logic [31:0] exp_dw);
        int   lat;
        logic saw_we;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        check({tag, " ready"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (!exp_err) begin
            check({tag, " mem_we"}, {31'd0, bus.d_we}, {31'd0, we});
            check({tag, " mem_be"}, {28'd0, bus.d_be}, {28'd0, exp_be});
            check({tag, " mem_addr"}, {17'd0, bus.d_addr}, exp_daddr);
            if (we) check({tag, " mem_wdata"}, bus.d_wdata, exp_dw);
        end
        lat = 1;
        saw_we = 1'b0;
        while (!bus.resp_valid && lat < 10) begin
            saw_we |= bus.d_we;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " err"}, {31'd0, bus.resp_err}, {31'd0, exp_err});
        check({tag, " rdata"}, bus.resp_rdata, exp_rd);
        if (exp_err) check({tag, " no_we"}, {31'd0, saw_we}, 32'd0);
        @(negedge clk);
        check({tag, " idle"}, {bus.resp_valid, bus.resp_err, bus.resp_rdata[29:0]}, 32'd0);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        #12;
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp", {bus.resp_valid, bus.resp_err, bus.resp_rdata[29:0]}, 32'd0);
        check("rst_d", {bus.d_we, bus.d_be, 12'd0, bus.d_addr}, 32'd0);
        check("rst_wdata", bus.d_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        req("sw10", 1, 3'd2, 32'h10, 32'hDEADBEEF, 2, 0, 32'd0, 32'd4, 4'b1111, 32'hDEADBEEF);
        req("sb13", 1, 3'd0, 32'h13, 32'h000000A5, 2, 0, 32'd0, 32'd4, 4'b1000, 32'hA5A5A5A5);
        req("lw10", 0, 3'd2, 32'h10, 32'd0, 3, 0, 32'hA5ADBEEF, 32'd4, 4'b0000, 32'd0);
        req("sw20", 1, 3'd2, 32'h20, 32'h80817F80, 2, 0, 32'd0, 32'd8, 4'b1111, 32'h80817F80);
        req("lb21", 0, 3'd0, 32'h21, 32'd0, 3, 0, 32'h0000007F, 32'd8, 4'b0000, 32'd0);
        req("lb20", 0, 3'd0, 32'h20, 32'd0, 3, 0, 32'hFFFFFF80, 32'd8, 4'b0000, 32'd0);
        req("lbu20", 0, 3'd4, 32'h20, 32'd0, 3, 0, 32'h00000080, 32'd8, 4'b0000, 32'd0);
        req("lh22", 0, 3'd1, 32'h22, 32'd0, 3, 0, 32'hFFFF8081, 32'd8, 4'b0000, 32'd0);
        req("lhu22", 0, 3'd5, 32'h22, 32'd0, 3, 0, 32'h00008081, 32'd8, 4'b0000, 32'd0);
        req("lh20", 0, 3'd1, 32'h20, 32'd0, 3, 0, 32'h00007F80, 32'd8, 4'b0000, 32'd0);
        req("sh22", 1, 3'd1, 32'h22, 32'h00001234, 2, 0, 32'd0, 32'd8, 4'b1100, 32'h12341234);
        req("lw20", 0, 3'd2, 32'h20, 32'd0, 3, 0, 32'h12347F80, 32'd8, 4'b0000, 32'd0);

        req("e_lw02", 0, 3'd2, 32'h02, 32'd0, 1, 1, 32'd0, 32'd0, 4'd0, 32'd0);
        req("e_sh01", 1, 3'd1, 32'h01, 32'hFFFF, 1, 1, 32'd0, 32'd0, 4'd0, 32'd0);
        req("e_ld3", 0, 3'd3, 32'h00, 32'd0, 1, 1, 32'd0, 32'd0, 4'd0, 32'd0);
        req("e_st4", 1, 3'd4, 32'h00, 32'h1, 1, 1, 32'd0, 32'd0, 4'd0, 32'd0);

        req("sw_wrap", 1, 3'd2, 32'h0002_0040, 32'h55, 2, 0, 32'd0, 32'h10, 4'b1111, 32'h55);
        req("lw40", 0, 3'd2, 32'h40, 32'd0, 3, 0, 32'h55, 32'h10, 4'b0000, 32'd0);

        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = 32'h11111111;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("rstmid_we_before", {31'd0, bus.d_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("rstmid_we_after", {31'd0, bus.d_we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                seen |= bus.resp_valid;
            end
            check("rstmid_no_resp", {31'd0, seen}, 32'd0);
        end
        req("sw30", 1, 3'd2, 32'h30, 32'h22222222, 2, 0, 32'd0, 32'hC, 4'b1111, 32'h22222222);
        req("lw30", 0, 3'd2, 32'h30, 32'd0, 3, 0, 32'h22222222, 32'hC, 4'b0000, 32'd0);

        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h50;
        bus.req_wdata  = 32'hAAAA0001;
        @(negedge clk);
        check("b2b_mem1", {bus.d_we, bus.req_ready, 15'd0, bus.d_addr}, {1'b1, 1'b0, 15'd0, 15'h14});
        check("b2b_wd1", bus.d_wdata, 32'hAAAA0001);
        bus.req_addr  = 32'h54;
        bus.req_wdata = 32'hBBBB0002;
        @(negedge clk);
        check("b2b_resp1", {30'd0, bus.resp_valid, bus.req_ready}, 32'd2);
        @(negedge clk);
        check("b2b_idle", {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b_mem2", {bus.d_we, 16'd0, bus.d_addr}, {1'b1, 16'd0, 15'h15});
        check("b2b_wd2", bus.d_wdata, 32'hBBBB0002);
        @(negedge clk);
        check("b2b_resp2", {31'd0, bus.resp_valid}, 32'd1);
        @(negedge clk);
        req("lw50", 0, 3'd2, 32'h50, 32'd0, 3, 0, 32'hAAAA0001, 32'h14, 4'b0000, 32'd0);
        req("lw54", 0, 3'd2, 32'h54, 32'd0, 3, 0, 32'hBBBB0002, 32'h15, 4'b0000, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
